// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width and the occupancy-counter
// width helper used by the RX/TX buffers and status registers.
package uart_pkg;

  localparam int DLEN_DEF = 8;

  // A buffer of 'depth' entries needs one extra bit to represent "completely full".
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DLEN character storage: synchronous write, asynchronous read.
// Contents are deliberately not reset; the owning FIFO tracks validity.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DLEN  = DLEN_DEF,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DLEN-1:0]          wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DLEN-1:0]          rdata_o
);

  logic [DLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT valid/ready output, drop-on-full
// input (the receiver cannot be stalled) with a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DLEN  = DLEN_DEF,
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_rvalid,
  input  logic [DLEN-1:0]           i_rdata,
  output logic                      o_tvalid,
  output logic [DLEN-1:0]           o_tdata,
  input  logic                      i_tready,
  output logic [cnt_w(DEPTH)-1:0]   o_count,
  output logic                      o_full,
  output logic                      o_afull,
  output logic                      o_overflow,
  input  logic                      i_ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, do_wr, do_rd, drop;

  // Handshake: a character leaves on any cycle where o_tvalid && i_tready;
  // o_tvalid comes only from the registered count, never from i_tready.
  assign full  = (count_q == CW'(DEPTH));
  assign do_rd = o_tvalid && i_tready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign do_wr = i_rvalid && (!full || do_rd);
  assign drop  = i_rvalid && full && !do_rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)           ovf_d = 1'b1;
    else if (i_ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .DLEN  (DLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_rdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (o_tdata)
  );

  assign o_tvalid   = (count_q != '0);
  assign o_count    = count_q;
  assign o_full     = full;
  assign o_afull    = (count_q >= CW'(AFULL));
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: expected data comes from a queue scoreboard,
// flag expectations are hand-computed for DEPTH=16, AFULL=12.
module tb_uart_rx_fifo;

  localparam int DLEN  = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_rvalid = 1'b0;
  logic [DLEN-1:0] i_rdata = '0;
  logic            i_tready = 1'b0;
  logic            i_ovf_clr = 1'b0;
  logic            o_tvalid;
  logic [DLEN-1:0] o_tdata;
  logic [4:0]      o_count;
  logic            o_full, o_afull, o_overflow;

  logic [DLEN-1:0] exp_q[$];
  int              checks = 0;
  int              errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  uart_rx_fifo #(.DLEN(DLEN), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .o_tvalid   (o_tvalid),
    .o_tdata    (o_tdata),
    .i_tready   (i_tready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_afull    (o_afull),
    .o_overflow (o_overflow),
    .i_ovf_clr  (i_ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs driven at negedge, state observed at the next negedge.
  task automatic cyc(input logic rv, input logic [DLEN-1:0] d, input logic rdy,
                     input logic clr);
    bit popped;
    popped    = 1'b0;
    i_rvalid  = rv;
    i_rdata   = d;
    i_tready  = rdy;
    i_ovf_clr = clr;
    chk("tvalid", {31'd0, o_tvalid}, {31'd0, exp_q.size() != 0});
    if (rdy && exp_q.size() != 0) begin
      chk("rd_data", {24'd0, o_tdata}, {24'd0, exp_q.pop_front()});
      popped = 1'b1;
    end
    if (rv && (exp_q.size() < DEPTH)) exp_q.push_back(d);
    @(negedge clk);
    i_rvalid  = 1'b0;
    i_tready  = 1'b0;
    i_ovf_clr = 1'b0;
    chk("count", {27'd0, o_count}, exp_q.size());
  endtask

  task automatic do_reset(input logic rv, input logic [DLEN-1:0] d);
    rst      = 1'b1;
    i_rvalid = rv;
    i_rdata  = d;
    @(negedge clk);
    rst      = 1'b0;
    i_rvalid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    // reset state
    @(negedge clk);
    do_reset(1'b0, 8'h00);
    chk("rst_tvalid", {31'd0, o_tvalid}, 0);
    chk("rst_count", {27'd0, o_count}, 0);
    chk("rst_full", {31'd0, o_full}, 0);
    chk("rst_afull", {31'd0, o_afull}, 0);
    chk("rst_ovf", {31'd0, o_overflow}, 0);

    // single character, one-cycle latency
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("lat_tvalid", {31'd0, o_tvalid}, 1);
    chk("lat_tdata", {24'd0, o_tdata}, 32'hA5);
    chk("lat_count", {27'd0, o_count}, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_tvalid", {31'd0, o_tvalid}, 0);
    chk("pop_count", {27'd0, o_count}, 0);

    // fill to full, watching the almost-full threshold
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_afull", {31'd0, o_afull}, {31'd0, (i + 1) >= 12});
      chk("fill_full", {31'd0, o_full}, {31'd0, (i + 1) == 16});
    end
    chk("full_count", {27'd0, o_count}, 16);

    // overflow: 0x77 dropped, contents unchanged
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, o_overflow}, 1);
    chk("ovf_count", {27'd0, o_count}, 16);
    chk("ovf_head", {24'd0, o_tdata}, 32'h00);

    // drain in order 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_full", {31'd0, o_full}, 0);
      chk("drain_afull", {31'd0, o_afull}, {31'd0, (15 - i) >= 12});
    end
    chk("drain_tvalid", {31'd0, o_tvalid}, 0);
    chk("ovf_sticky", {31'd0, o_overflow}, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", {31'd0, o_overflow}, 0);

    // set beats clear in the same cycle
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk("ovf_prio", {31'd0, o_overflow}, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", {31'd0, o_overflow}, 0);

    // full with simultaneous push and pop: nothing dropped
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("pp_count", {27'd0, o_count}, 16);
    chk("pp_full", {31'd0, o_full}, 1);
    chk("pp_ovf", {31'd0, o_overflow}, 0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_last", {24'd0, o_tdata}, 32'h55);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pp_empty", {31'd0, o_tvalid}, 0);

    // streaming: write into empty with ready high, then 39 push+pop cycles
    cyc(1'b1, 8'h03, 1'b1, 1'b0);
    for (int i = 1; i < 40; i++) begin
      cyc(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
      chk("stream_le1", {31'd0, o_count <= 5'd1}, 1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_end", {27'd0, o_count}, 0);

    // reset mid-operation with a character arriving during reset
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", {27'd0, o_count}, 5);
    chk("pre_rst_ovf", {31'd0, o_overflow}, 1);
    do_reset(1'b1, 8'hEE);
    chk("mid_rst_count", {27'd0, o_count}, 0);
    chk("mid_rst_tvalid", {31'd0, o_tvalid}, 0);
    chk("mid_rst_ovf", {31'd0, o_overflow}, 0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_tdata", {24'd0, o_tdata}, 32'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each single-cycle received character (i_rvalid/i_rdata) into a DEPTH-entry circular buffer. It presents characters to the consumer over a valid/ready stream in first-word-fall-through order. Overflow is flagged, not stalled, because the receiver has no backpressure: characters that arrive while the buffer is full are dropped and a sticky flag is raised.

Parameters:
DLEN, 8, character width in bits; must equal the receiver's DLEN.
DEPTH, 16, buffer entries; power of two, minimum 2.
AFULL, 12, almost-full threshold in entries; 1 <= AFULL <= DEPTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
i_rvalid  input  1  one-cycle strobe, character available from receiver
i_rdata  input  DLEN  received character, valid when i_rvalid=1
o_tvalid  output  1  buffer non-empty, o_tdata valid
o_tdata  output  DLEN  oldest buffered character
i_tready  input  1  consumer accepts o_tdata when o_tvalid&&i_tready
o_count  output  $clog2(DEPTH)+1  number of entries held
o_full  output  1  o_count==DEPTH
o_afull  output  1  o_count>=AFULL
o_overflow  output  1  sticky, a character was dropped
i_ovf_clr  input  1  clears o_overflow

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. rst dominates every other input in the same cycle.
- Reset values: o_tvalid=0, o_count=0, o_full=0, o_afull=0, o_overflow=0, and read/write pointers =0.
- o_tdata is undefined while o_tvalid=0. Storage contents are not reset.
- Reset mid-operation discards all buffered data. The first i_rvalid after rst deasserts is stored normally.
- Write: i_rvalid=1 and (not full, or a read occurs in the same cycle) stores i_rdata at wr_ptr, then wr_ptr increments.
- Read: o_tvalid&&i_tready pops the entry at rd_ptr, then rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count: +1 on write only, -1 on read only, unchanged on simultaneous write+read. It never exceeds DEPTH and never underflows.
- Latency: a write into an empty buffer gives o_tvalid=1 on the next cycle, with o_tdata equal to that character. FWFT: o_tdata is a combinational read of mem[rd_ptr].
- o_tvalid, o_full and o_afull are derived from the registered count, with no extra latency.
- Boundary: full, with i_rvalid and i_tready both high: the pop and push both occur, count stays at DEPTH, and nothing is dropped.
- Boundary: full, with i_rvalid high and no read: i_rdata is dropped and o_overflow=1 from the next cycle. Buffer contents and pointers are unchanged.
- Boundary: empty with i_tready high: no pop occurs, and a simultaneous i_rvalid write is accepted normally.
- o_overflow: set has priority over i_ovf_clr in the same cycle. Otherwise i_ovf_clr=1 clears the flag on the next cycle.
- o_tvalid must not depend combinationally on i_tready.
- No state machine is required. Control consists of the pointers, the count and the sticky flag.

Decomposition:
- Shared package uart_pkg:
  - default DLEN constant, 8;
  - function cnt_w(depth), returning $clog2(depth)+1, used by this block and by future TX FIFO and status-register blocks.
- One sub-module, uart_fifo_mem:
  - DEPTH x DLEN storage with synchronous write and asynchronous read;
  - reused by the future transmit-side FIFO.

Test Plan:
- Reset, then write 0xA5 with i_tready=0 -> next cycle o_tvalid=1, o_tdata=0xA5, o_count=1. Raise i_tready for one cycle -> o_count=0, o_tvalid=0.
- Write 16 characters 0x00..0x0F with i_tready=0 -> o_full=1, o_count=16, and o_afull first asserts after the 12th write. Drain -> read order is 0x00..0x0F, and o_full/o_afull deassert accordingly.
- Full buffer, write 0x77 with i_tready=0 -> o_overflow=1 next cycle, count stays 16, and drained data excludes 0x77. Pulse i_ovf_clr -> o_overflow=0.
- Full buffer, i_rvalid=1 with 0x55 and i_tready=1 in the same cycle -> count stays 16, no overflow, and 0x55 is the last character drained.
- Continuous write+read for 40 characters, exercising pointer wrap -> output sequence matches input exactly, and count never exceeds 1.
- Load 5 entries, assert rst for one cycle while i_rvalid=1 -> o_count=0, o_tvalid=0, o_overflow=0, and the character written during reset is not stored.
